// File: rtl/ram_burst_master_if.sv
// Handshake and RAM-bus bundle for ram_burst_master.
// The master modport is the burst engine's view; slave is the RAM/requester side.
interface ram_burst_master_if #(
   parameter int LEN_W = 4
);
   logic             Req_valid;
   logic             Req_ready;
   logic             Req_write;
   logic [7:0]       Req_addr;
   logic [LEN_W-1:0] Req_len;
   logic             Wr_valid;
   logic             Wr_ready;
   logic [7:0]       Wr_data;
   logic             Rd_valid;
   logic [7:0]       Rd_data;
   logic             Done;
   logic             Cs;
   logic             Wen;
   logic             Oen;
   logic [7:0]       Address;
   logic [7:0]       DataIn;
   logic [7:0]       DataOut;

   modport master (
      input  Req_valid, Req_write, Req_addr, Req_len, Wr_valid, Wr_data, DataOut,
      output Req_ready, Wr_ready, Rd_valid, Rd_data, Done,
             Cs, Wen, Oen, Address, DataIn
   );

   modport slave (
      output Req_valid, Req_write, Req_addr, Req_len, Wr_valid, Wr_data, DataOut,
      input  Req_ready, Wr_ready, Rd_valid, Rd_data, Done,
             Cs, Wen, Oen, Address, DataIn
   );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for the 8-bit register RAM: one read or write burst of 1..2**LEN_W
// beats with incrementing (mod 256) address, registered RAM strobes.
module ram_burst_master #(
   parameter int LEN_W = 4
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   ram_burst_master_if.master     bus
);

   typedef enum logic [2:0] {IDLE, WRITE, WR_LAST, READ, DRAIN} state_e;

   state_e           state_q, state_d;
   logic [7:0]       cur_q, cur_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [1:0]       iv_q, iv_d;
   logic             cs_q, cs_d;
   logic             wen_q, wen_d;
   logic             oen_q, oen_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       din_q, din_d;
   logic             rd_valid_q, rd_valid_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             done_q, done_d;

   always_comb begin
      // NOTE: every _d starts from its _q (or a safe constant) so no branch can infer a latch.
      state_d    = state_q;
      cur_d      = cur_q;
      rem_d      = rem_q;
      cs_d       = cs_q;
      wen_d      = wen_q;
      oen_d      = oen_q;
      addr_d     = addr_q;
      din_d      = din_q;
      done_d     = 1'b0;
      // iv[0]: read beat on the bus this cycle; iv[1]: its data is on DataOut this cycle.
      iv_d       = {iv_q[0], 1'b0};
      rd_valid_d = iv_q[1];
      rd_data_d  = iv_q[1] ? bus.DataOut : rd_data_q;

      case (state_q)
         IDLE: begin
            cs_d  = 1'b0;
            wen_d = 1'b0;
            oen_d = 1'b0;
            if (bus.Req_valid) begin
               cur_d   = bus.Req_addr;
               rem_d   = bus.Req_len;
               state_d = bus.Req_write ? WRITE : READ;
            end
         end
         WRITE: begin
            oen_d = 1'b0;
            if (bus.Wr_valid) begin
               cs_d   = 1'b1;
               wen_d  = 1'b1;
               addr_d = cur_q;
               din_d  = bus.Wr_data;
               cur_d  = cur_q + 8'd1;
               if (rem_q == '0) state_d = WR_LAST;
               else             rem_d   = rem_q - LEN_W'(1);
            end else begin
               cs_d  = 1'b0;
               wen_d = 1'b0;
            end
         end
         WR_LAST: begin
            cs_d    = 1'b0;
            wen_d   = 1'b0;
            oen_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         READ: begin
            cs_d    = 1'b1;
            oen_d   = 1'b1;
            wen_d   = 1'b0;
            addr_d  = cur_q;
            cur_d   = cur_q + 8'd1;
            iv_d[0] = 1'b1;
            if (rem_q == '0) state_d = DRAIN;
            else             rem_d   = rem_q - LEN_W'(1);
         end
         DRAIN: begin
            cs_d  = 1'b0;
            wen_d = 1'b0;
            oen_d = 1'b0;
            // Last beat's data is being captured on this edge: Done lines up with its Rd_valid.
            if (iv_q == 2'b10) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
      if (!Rst_n) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         rem_q      <= '0;
         iv_q       <= '0;
         cs_q       <= 1'b0;
         wen_q      <= 1'b0;
         oen_q      <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         rem_q      <= rem_d;
         iv_q       <= iv_d;
         cs_q       <= cs_d;
         wen_q      <= wen_d;
         oen_q      <= oen_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         done_q     <= done_d;
      end
   end

   assign bus.Req_ready = (state_q == IDLE);
   assign bus.Wr_ready  = (state_q == WRITE);
   assign bus.Cs        = cs_q;
   assign bus.Wen       = wen_q;
   assign bus.Oen       = oen_q;
   assign bus.Address   = addr_q;
   assign bus.DataIn    = din_q;
   assign bus.Rd_valid  = rd_valid_q;
   assign bus.Rd_data   = rd_data_q;
   assign bus.Done      = done_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: RAM model, bus monitor and a memory-image reference
// model that predicts strobes, read data and cycle timing of each burst.
module tb_ram_burst_master;

   logic Clk = 1'b0;
   logic Rst_n;
   always #5 Clk = ~Clk;

   ram_burst_master_if #(.LEN_W(4)) bus ();

   ram_burst_master #(.LEN_W(4)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      int         c;
   } ev_t;

   int         cyc = 0;
   int         n_assert = 0;
   int         n_fail = 0;
   int         bad_cnt = 0;
   logic [7:0] mem [256];
   logic [7:0] exp_mem [256];
   ev_t        wq[$];
   ev_t        rbq[$];
   ev_t        rq[$];
   int         acc_q[$];
   int         done_q[$];

   always @(posedge Clk) cyc <= cyc + 1;

   // RAM: write on Cs&Wen; read data appears the cycle after Cs&Oen is sampled.
   always @(posedge Clk) begin
      if (bus.Cs && bus.Wen) mem[bus.Address] = bus.DataIn;
      bus.DataOut <= (bus.Cs && bus.Oen) ? mem[bus.Address] : 8'($urandom);
   end

   always @(negedge Clk) begin
      if (bus.Req_valid && bus.Req_ready) acc_q.push_back(cyc + 1);
      if (bus.Cs && bus.Wen) wq.push_back('{a: bus.Address, d: bus.DataIn, c: cyc});
      if (bus.Cs && bus.Oen) rbq.push_back('{a: bus.Address, d: 8'h00, c: cyc});
      if (bus.Wen && bus.Oen) bad_cnt++;
      if (bus.Rd_valid) rq.push_back('{a: 8'h00, d: bus.Rd_data, c: cyc});
      if (bus.Done) done_q.push_back(cyc);
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cmd_drive(input logic wr, input logic [7:0] addr, input int len);
      bus.Req_write = wr;
      bus.Req_addr  = addr;
      bus.Req_len   = 4'(len);
      bus.Req_valid = 1'b1;
   endtask

   task automatic cmd_wait(input int n0, output int a);
      int t = 0;
      while (acc_q.size() <= n0 && t < 60) begin
         tick();
         t++;
      end
      check("accept_seen", 32'(acc_q.size() > n0), 1);
      a = (acc_q.size() > n0) ? acc_q[n0] : 0;
      bus.Req_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int t = 0;
      while (done_q.size() <= d0 && t < 80) begin
         tick();
         t++;
      end
      check("done_seen", 32'(done_q.size() > d0), 1);
      tick();
      tick();
      check("single_done", done_q.size() - d0, 1);
   endtask

   task automatic write_body(input logic [7:0] addr, input int len, input logic [7:0] d [16],
                             input int bub [16], input int w0, input int d0);
      int gap = 0;
      for (int i = 0; i <= len; i++) begin
         for (int b = 0; b < bub[i]; b++) begin
            bus.Wr_valid = 1'b0;
            bus.Wr_data  = 8'($urandom);
            tick();
         end
         if (i > 0) gap += bub[i];
         bus.Wr_valid = 1'b1;
         bus.Wr_data  = d[i];
         check("wr_ready", 32'(bus.Wr_ready), 1);
         check("req_ready_busy", 32'(bus.Req_ready), 0);
         tick();
      end
      bus.Wr_valid = 1'b0;
      for (int i = 0; i <= len; i++) exp_mem[8'(addr + 8'(i))] = d[i];
      wait_done(d0);
      check("wr_count", wq.size() - w0, len + 1);
      if (wq.size() - w0 == len + 1) begin
         for (int i = 0; i <= len; i++) begin
            check("wr_addr", wq[w0 + i].a, 8'(addr + 8'(i)));
            check("wr_data", wq[w0 + i].d, d[i]);
         end
         check("wr_span", wq[w0 + len].c - wq[w0].c + 1, len + 1 + gap);
         if (done_q.size() > d0) check("wr_done_cyc", done_q[d0], wq[w0 + len].c + 1);
      end
   endtask

   task automatic write_burst(input logic [7:0] addr, input int len, input logic [7:0] d [16],
                              input int bub [16]);
      int a;
      int n0 = acc_q.size();
      int w0 = wq.size();
      int d0 = done_q.size();
      cmd_drive(1'b1, addr, len);
      cmd_wait(n0, a);
      write_body(addr, len, d, bub, w0, d0);
   endtask

   task automatic read_body(input int a, input logic [7:0] addr, input int len,
                            input int rb0, input int q0, input int d0);
      wait_done(d0);
      check("rd_beats", rbq.size() - rb0, len + 1);
      check("rd_count", rq.size() - q0, len + 1);
      for (int i = 0; i <= len; i++) begin
         logic [7:0] ea = addr + 8'(i);
         if (rb0 + i < rbq.size()) begin
            check("rd_addr", rbq[rb0 + i].a, ea);
            check("rd_beat_cyc", rbq[rb0 + i].c, a + 1 + i);
         end
         if (q0 + i < rq.size()) begin
            check("rd_data", rq[q0 + i].d, exp_mem[ea]);
            check("rd_valid_cyc", rq[q0 + i].c, a + 3 + i);
         end
      end
      if (done_q.size() > d0) check("rd_done_cyc", done_q[d0], a + len + 3);
   endtask

   task automatic read_burst(input logic [7:0] addr, input int len);
      int a;
      int n0  = acc_q.size();
      int rb0 = rbq.size();
      int q0  = rq.size();
      int d0  = done_q.size();
      cmd_drive(1'b0, addr, len);
      cmd_wait(n0, a);
      read_body(a, addr, len, rb0, q0, d0);
   endtask

   initial begin
      logic [7:0] d [16];
      int         bub [16];
      int         a, a2, n0, w0, d0, rb0, q0, rc, stray;
      logic [7:0] ra;
      int         rl;

      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'($urandom);
         exp_mem[i] = mem[i];
      end
      Rst_n         = 1'b0;
      bus.Req_valid = 1'b0;
      bus.Req_write = 1'b0;
      bus.Req_addr  = 8'h00;
      bus.Req_len   = 4'h0;
      bus.Wr_valid  = 1'b0;
      bus.Wr_data   = 8'h00;
      repeat (3) tick();

      check("rst_strobes", {bus.Cs, bus.Wen, bus.Oen, bus.Rd_valid, bus.Done}, 5'b0);
      check("rst_address", bus.Address, 8'h00);
      check("rst_datain", bus.DataIn, 8'h00);
      check("rst_rd_data", bus.Rd_data, 8'h00);
      check("rst_req_ready", 32'(bus.Req_ready), 1);
      check("rst_wr_ready", 32'(bus.Wr_ready), 0);
      Rst_n = 1'b1;
      tick();

      // Single-beat write.
      for (int i = 0; i < 16; i++) bub[i] = 0;
      d[0] = 8'hA5;
      write_burst(8'h10, 0, d, bub);
      check("ram_10", mem[8'h10], 8'hA5);

      // Four-beat write with a two-cycle Wr_valid gap before the third beat.
      for (int i = 0; i < 4; i++) d[i] = 8'(i + 1);
      bub[2] = 2;
      write_burst(8'h20, 3, d, bub);
      bub[2] = 0;
      for (int i = 0; i < 4; i++) check("ram_2x", mem[8'h20 + 8'(i)], 8'(i + 1));

      // Read back with Wr_valid held high, which must not produce write strobes.
      w0 = wq.size();
      bus.Wr_valid = 1'b1;
      bus.Wr_data  = 8'hEE;
      read_burst(8'h20, 3);
      bus.Wr_valid = 1'b0;
      check("wr_ignored", wq.size() - w0, 0);

      // Address wrap FE, FF, 00.
      d[0] = 8'h5A; d[1] = 8'hC3; d[2] = 8'h3C;
      write_burst(8'hFE, 2, d, bub);
      read_burst(8'hFE, 2);

      // Request held through a write burst; the queued read must wait for Done.
      n0 = acc_q.size(); w0 = wq.size(); d0 = done_q.size();
      rb0 = rbq.size(); q0 = rq.size();
      cmd_drive(1'b1, 8'h80, 2);
      cmd_wait(n0, a);
      cmd_drive(1'b0, 8'h80, 2);
      for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
      write_body(8'h80, 2, d, bub, w0, d0);
      cmd_wait(n0 + 1, a2);
      if (done_q.size() > d0) check("accept_after_done", 32'(a2 > done_q[d0]), 1);
      read_body(a2, 8'h80, 2, rb0, q0, d0 + 1);

      // Randomised write/read-back bursts.
      for (int k = 0; k < 6; k++) begin
         ra = 8'($urandom);
         rl = $urandom_range(0, 15);
         for (int i = 0; i < 16; i++) begin
            d[i]   = 8'($urandom);
            bub[i] = $urandom_range(0, 2);
         end
         write_burst(ra, rl, d, bub);
         read_burst(ra, rl);
         read_burst(8'($urandom), $urandom_range(0, 15));
      end

      // Reset in the middle of an eight-beat read.
      n0 = acc_q.size();
      cmd_drive(1'b0, 8'h40, 7);
      cmd_wait(n0, a);
      repeat (3) tick();
      Rst_n = 1'b0;
      rc    = cyc;
      tick();
      check("midrst_strobes", {bus.Cs, bus.Wen, bus.Oen, bus.Rd_valid, bus.Done}, 5'b0);
      check("midrst_address", bus.Address, 8'h00);
      tick();
      Rst_n = 1'b1;
      tick();
      check("midrst_req_ready", 32'(bus.Req_ready), 1);
      repeat (10) tick();
      stray = 0;
      foreach (rq[i])     if (rq[i].c > rc)  stray++;
      foreach (rbq[i])    if (rbq[i].c > rc) stray++;
      foreach (done_q[i]) if (done_q[i] > rc) stray++;
      check("midrst_no_stray", stray, 0);

      // Recovery after reset.
      read_burst(8'h20, 3);

      check("never_wen_oen", bad_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
